// File: rtl/drive_mode_pkg.sv
// Shared types and constants for the rover drive-mode controller.
//   mode_t  : top-level operating mode (IDLE / CAM / IR)
//   cam_t   : autonomous-follow sub-state
//   drive_t : command sent to the motor PWM driver
//   CODE_*  : decoded IR remote keys
//   HEX_*   : active-low {g,f,e,d,c,b,a} seven-segment glyphs for the mode display
package drive_mode_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_CAM  = 2'b01,
    MODE_IR   = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    CAM_SEARCH = 2'b00,
    CAM_FOLLOW = 2'b01,
    CAM_LOST   = 2'b10,
    CAM_PAUSE  = 2'b11
  } cam_t;

  typedef enum logic [2:0] {
    DRV_STOP  = 3'b000,
    DRV_LEFT  = 3'b001,
    DRV_RIGHT = 3'b010,
    DRV_FWD   = 3'b011,
    DRV_REV   = 3'b100
  } drive_t;

  localparam logic [7:0] CODE_CAM    = 8'h0F;
  localparam logic [7:0] CODE_IR     = 8'h13;
  localparam logic [7:0] CODE_IDLE   = 8'h10;
  localparam logic [7:0] CODE_FWD    = 8'h02;
  localparam logic [7:0] CODE_LEFT   = 8'h04;
  localparam logic [7:0] CODE_RIGHT  = 8'h06;
  localparam logic [7:0] CODE_REV    = 8'h08;
  localparam logic [7:0] CODE_STOP   = 8'h05;
  localparam logic [7:0] CODE_SPD_UP = 8'h01;
  localparam logic [7:0] CODE_SPD_DN = 8'h03;

  localparam logic [6:0] HEX_IDLE = 7'b0111111;  // '-'
  localparam logic [6:0] HEX_CAM  = 7'b1000110;  // 'C'
  localparam logic [6:0] HEX_IR   = 7'b1111001;  // '1'

  function automatic logic [6:0] hex_glyph(input mode_t m);
    case (m)
      MODE_CAM: hex_glyph = HEX_CAM;
      MODE_IR:  hex_glyph = HEX_IR;
      default:  hex_glyph = HEX_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/presence_filter.sv
// Debounce for the raw target-detected flag.
//   clk_50      in  system clock
//   reset_n     in  synchronous reset, active low
//   target_seen in  raw detection flag
//   seen_f      out high once target_seen has been high for N consecutive cycles
// The counter saturates at N and drops to zero on any low sample.
module presence_filter #(
  parameter int N = 4
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic target_seen,
  output logic seen_f
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = '0;
    if (target_seen) begin
      count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign seen_f = (count_q == CNT_MAX);

endmodule

// File: rtl/drive_mode_controller.sv
// Rover mode arbiter between the IR decoder / camera tracker and the motor PWM driver.
//   clk_50      in   50 MHz system clock
//   reset_n     in   synchronous reset, active low
//   ir_valid    in   one-cycle strobe, ir_code holds a new key
//   ir_code     in   decoded remote key
//   cam_dir     in   001 left, 010 right, 011 centre, other = no bearing
//   cam_speed   in   requested follow speed
//   target_seen in   raw target-detected flag
//   mode        out  mode_t
//   cam_state   out  cam_t
//   drive_cmd   out  drive_t
//   drive_speed out  speed for drive_cmd
//   mode_change out  one-cycle pulse when mode or cam_state changes
//   hex_mode    out  active-low mode glyph for HEX7
// All outputs are registered; every next-state value is derived from the
// next mode so that mode, cam_state and drive change on the same edge.
module drive_mode_controller
  import drive_mode_pkg::*;
#(
  parameter int SPEED_W      = 2,
  parameter int MAX_SPEED    = 2,
  parameter int SEARCH_SPEED = 0,
  parameter int DET_CYCLES   = 4,
  parameter int LOST_CYCLES  = 25_000_000,
  parameter int IR_TIMEOUT   = 12_500_000
) (
  input  logic               clk_50,
  input  logic               reset_n,
  input  logic               ir_valid,
  input  logic [7:0]         ir_code,
  input  logic [2:0]         cam_dir,
  input  logic [SPEED_W-1:0] cam_speed,
  input  logic               target_seen,
  output logic [1:0]         mode,
  output logic [1:0]         cam_state,
  output logic [2:0]         drive_cmd,
  output logic [SPEED_W-1:0] drive_speed,
  output logic               mode_change,
  output logic [6:0]         hex_mode
);

  localparam int LOST_W = $clog2(LOST_CYCLES + 1);
  localparam int WD_W   = $clog2(IR_TIMEOUT + 1);

  localparam logic [LOST_W-1:0]  LOST_LAST  = LOST_W'(LOST_CYCLES - 1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(IR_TIMEOUT - 1);
  localparam logic [SPEED_W-1:0] MAX_SPD    = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] SEARCH_SPD = SPEED_W'(SEARCH_SPEED);

  function automatic logic [SPEED_W-1:0] clamp_speed(input logic [SPEED_W-1:0] s);
    clamp_speed = (s > MAX_SPD) ? MAX_SPD : s;
  endfunction

  function automatic logic [SPEED_W-1:0] speed_up(input logic [SPEED_W-1:0] s);
    speed_up = (s >= MAX_SPD) ? MAX_SPD : s + SPEED_W'(1);
  endfunction

  function automatic logic [SPEED_W-1:0] speed_dn(input logic [SPEED_W-1:0] s);
    speed_dn = (s == '0) ? '0 : s - SPEED_W'(1);
  endfunction

  mode_t              mode_q, mode_d;
  cam_t               cam_q, cam_d;
  drive_t             drive_cmd_q, drive_cmd_d;
  logic [SPEED_W-1:0] drive_speed_q, drive_speed_d;
  logic               mode_change_q, mode_change_d;
  logic [6:0]         hex_q, hex_d;
  drive_t             man_cmd_q, man_cmd_d;
  logic [SPEED_W-1:0] man_spd_q, man_spd_d;
  logic [LOST_W-1:0]  lost_cnt_q, lost_cnt_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic               seen_f;

  presence_filter #(
    .N (DET_CYCLES)
  ) u_presence_filter (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .target_seen (target_seen),
    .seen_f      (seen_f)
  );

  // Mode selection and camera sub-FSM
  always_comb begin
    mode_d = mode_q;
    if (ir_valid) begin
      case (ir_code)
        CODE_CAM:  mode_d = MODE_CAM;
        CODE_IR:   mode_d = MODE_IR;
        CODE_IDLE: mode_d = MODE_IDLE;
        default:   mode_d = mode_q;
      endcase
    end

    cam_d = cam_q;
    if (mode_d != MODE_CAM) begin
      cam_d = CAM_PAUSE;
    end else begin
      case (cam_q)
        CAM_PAUSE:  cam_d = CAM_SEARCH;
        CAM_SEARCH: cam_d = seen_f ? CAM_FOLLOW : CAM_SEARCH;
        CAM_FOLLOW: cam_d = target_seen ? CAM_FOLLOW : CAM_LOST;
        CAM_LOST: begin
          // Re-acquisition takes priority over the timeout.
          if (seen_f) begin
            cam_d = CAM_FOLLOW;
          end else if (lost_cnt_q == LOST_LAST) begin
            cam_d = CAM_SEARCH;
          end else begin
            cam_d = CAM_LOST;
          end
        end
        default: cam_d = CAM_PAUSE;
      endcase
    end

    lost_cnt_d = '0;
    if (cam_q == CAM_LOST && cam_d == CAM_LOST) begin
      lost_cnt_d = lost_cnt_q + LOST_W'(1);
    end
  end

  // Manual IR driving and no-key watchdog
  always_comb begin
    man_cmd_d = man_cmd_q;
    man_spd_d = man_spd_q;
    wd_cnt_d  = '0;
    if (mode_d == MODE_IR) begin
      if (mode_q != MODE_IR) begin
        man_cmd_d = DRV_STOP;
      end else if (ir_valid) begin
        case (ir_code)
          CODE_FWD:    man_cmd_d = DRV_FWD;
          CODE_LEFT:   man_cmd_d = DRV_LEFT;
          CODE_RIGHT:  man_cmd_d = DRV_RIGHT;
          CODE_REV:    man_cmd_d = DRV_REV;
          CODE_STOP:   man_cmd_d = DRV_STOP;
          CODE_SPD_UP: man_spd_d = speed_up(man_spd_q);
          CODE_SPD_DN: man_spd_d = speed_dn(man_spd_q);
          default:     man_cmd_d = man_cmd_q;
        endcase
      end else if (wd_cnt_q == WD_LAST) begin
        // Park at the terminal count so STOP keeps being reasserted.
        man_cmd_d = DRV_STOP;
        wd_cnt_d  = wd_cnt_q;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end
  end

  // Output selection
  always_comb begin
    drive_cmd_d   = DRV_STOP;
    drive_speed_d = '0;
    case (mode_d)
      MODE_CAM: begin
        case (cam_d)
          CAM_SEARCH: begin
            drive_cmd_d   = DRV_RIGHT;
            drive_speed_d = SEARCH_SPD;
          end
          CAM_FOLLOW: begin
            case (cam_dir)
              3'b001: begin
                drive_cmd_d   = DRV_LEFT;
                drive_speed_d = clamp_speed(cam_speed);
              end
              3'b010: begin
                drive_cmd_d   = DRV_RIGHT;
                drive_speed_d = clamp_speed(cam_speed);
              end
              3'b011: begin
                drive_cmd_d   = DRV_FWD;
                drive_speed_d = clamp_speed(cam_speed);
              end
              default: begin
                drive_cmd_d   = DRV_STOP;
                drive_speed_d = '0;
              end
            endcase
          end
          CAM_LOST: begin
            drive_cmd_d   = drive_cmd_q;
            drive_speed_d = drive_speed_q;
          end
          default: begin
            drive_cmd_d   = DRV_STOP;
            drive_speed_d = '0;
          end
        endcase
      end
      MODE_IR: begin
        drive_cmd_d   = man_cmd_d;
        drive_speed_d = man_spd_d;
      end
      default: begin
        drive_cmd_d   = DRV_STOP;
        drive_speed_d = '0;
      end
    endcase

    mode_change_d = (mode_d != mode_q) || (cam_d != cam_q);
    hex_d         = hex_glyph(mode_d);
  end

  // State registers
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      mode_q        <= MODE_IDLE;
      cam_q         <= CAM_PAUSE;
      drive_cmd_q   <= DRV_STOP;
      drive_speed_q <= '0;
      mode_change_q <= 1'b0;
      hex_q         <= HEX_IDLE;
      man_cmd_q     <= DRV_STOP;
      man_spd_q     <= '0;
      lost_cnt_q    <= '0;
      wd_cnt_q      <= '0;
    end else begin
      mode_q        <= mode_d;
      cam_q         <= cam_d;
      drive_cmd_q   <= drive_cmd_d;
      drive_speed_q <= drive_speed_d;
      mode_change_q <= mode_change_d;
      hex_q         <= hex_d;
      man_cmd_q     <= man_cmd_d;
      man_spd_q     <= man_spd_d;
      lost_cnt_q    <= lost_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign mode        = mode_q;
  assign cam_state   = cam_q;
  assign drive_cmd   = drive_cmd_q;
  assign drive_speed = drive_speed_q;
  assign mode_change = mode_change_q;
  assign hex_mode    = hex_q;

endmodule
